mips_control_unit: RTL
======================

Name: mips_control_unit

Overview:
Multicycle main controller for the MIPS core. It consumes the opcode, funct field and ALU/mult/div status from the datapath, and drives every mux select and register-write strobe the datapath exposes. It is a Moore FSM, with one state per datapath micro-step. It covers fetch, decode, R/I/J execution, multiply/divide handshakes and the three exception entries.

Parameters:
MEM_WAIT, 2, wait cycles between memory address issue and data capture (fetch and lw).
SP_INIT, 227, stack-pointer value written to reg 29 on leaving reset (srcData sel 8).

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero, LT, GT, EQ, O  in  1 each  ALU flags; O = overflow
multDone, divDone  in  1 each  high one cycle when mult/div result valid
divZero  in  1  divisor==0, valid the cycle divControl is pulsed
iord, excpControl, excpCtrl, aluSrcA, aluSrcB, ssControl, lsControl  out  2 each  mux/size selects
srcWrite, pcSource, aluControl, shiftControl  out  3 each
srcData  out  4
shiftSrc, shiftAmt, srcRead  out  1 each
pcWrite, irWrite, regWrite, memWrite, abWrite, mdrWrite, aluOutControl, epcControl, hiLoWrite, multControl, divControl  out  1 each  strobes
state_dbg  out  6  current state code

Behaviour:
- Moore outputs: strobes and selects are decoded from the state only. In every state, any output not named defaults to 0.
- Reset asserted: state=RESET, all outputs 0.
  - First clk after release: regWrite=1, srcWrite=2 (reg 29), srcData=8 (SP_INIT). Then go to FETCH0.
  - Reset asserted mid-instruction returns to RESET immediately, with no partial writes.
- Select encodings:
  - iord: 0 PC, 1 ALUOut, 2 exception vector, 3 ALU result.
  - excpControl: 0 opcode→253, 1 overflow→254, 2 div0→255.
  - aluSrcA: 0 PC, 1 A, 2 MDR.
  - aluSrcB: 0 B, 1 const 4, 2 signext16, 3 signext16<<2.
  - pcSource: 0 result, 1 ALUOut, 2 jump concat, 3 MDR, 4 EPC, 5 LS.
  - srcWrite: 0 rt, 1 rd, 2 r29, 3 r30, 4 r31.
  - srcData: 0 ALUOut, 1 LS, 2 HI, 3 LO, 4 signext16, 5 shl16, 6 excpCtrl, 7 shiftReg, 8 SP_INIT.
  - aluControl: 000 passA, 001 add, 010 sub, 011 and, 111 compare.
  - shiftControl: 001 load, 010 sll, 011 srl, 100 sra.
- Fetch (MEM_WAIT+1 cycles):
  - FETCH0: iord=0, aluSrcA=0, aluSrcB=1, aluControl=add.
  - Wait states hold the same selects.
  - FETCH_LAST: irWrite=1, pcWrite=1, pcSource=0.
- DECODE (1 cycle): abWrite=1; ALUOut ← PC + (imm<<2) via aluSrcA=0, aluSrcB=3, add, aluOutControl=1. Then dispatch on opcode/funct.
- R-type add/sub/and:
  - EXEC: aluSrcA=1, aluSrcB=0, aluOutControl=1.
  - If O=1 on add/sub, go to EXCP with excpControl=1.
  - Otherwise WB: regWrite, srcWrite=1, srcData=0.
- sll/srl/sra (shiftSrc=1, shiftAmt=1):
  - SH_LOAD: shiftControl=001.
  - SH_OP: the shift op.
  - SH_WB: regWrite, srcData=7.
- jr: pcWrite, pcSource=0, aluSrcA=1, passA.
- mfhi/mflo: regWrite, srcWrite=1, srcData=2 or 3.
- mult/div:
  - MD_START pulses multControl or divControl for one cycle.
  - For div, divZero=1 in that cycle goes to EXCP with excpControl=2.
  - MD_WAIT holds until multDone/divDone, then hiLoWrite=1 for one cycle.
  - A done already high during MD_START is honoured.
- addi: aluSrcB=2, add. Overflow is handled as for R-type. WB uses srcWrite=0.
- slti: compare; WB uses srcData=0 with the ALUOut value taken from signext(LT).
- lui: regWrite, srcWrite=0, srcData=5 (1 cycle).
- beq/bne: aluSrcA=1, aluSrcB=0, compare. When EQ (beq) or !EQ (bne): pcWrite, pcSource=1. Otherwise no write.
- lw/sw:
  - ADDR: ALUOut ← A + signext16.
  - lw: iord=1 for MEM_WAIT cycles, then mdrWrite, then regWrite with srcData=1 and lsControl=0 (word).
  - sw: memWrite=1 with iord=1 and ssControl=0, one cycle.
- j: pcWrite, pcSource=2.
- jal:
  - First cycle: ALUOut ← PC (passA, aluSrcA=0).
  - Next cycle: regWrite, srcWrite=4, srcData=0, pcWrite, pcSource=2.
- rte: pcWrite, pcSource=4.
- Unknown opcode/funct: EXCP with excpControl=0.
- EXCP sequence:
  1. epcControl=1, EPC ← PC−4 (aluSrcA=0, aluSrcB=1, sub).
  2. iord=2 for MEM_WAIT cycles.
  3. mdrWrite.
  4. pcWrite with pcSource=5 and lsControl=2 (byte).
  5. FETCH0.
- Every instruction ends in FETCH0. No state may persist with no exit.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; next cycle regWrite=1, srcWrite=2, srcData=8; FETCH0 follows.
- opcode 0, funct 0x20, O=0 → FETCH(3), DECODE, EXEC, WB with regWrite=1, srcWrite=1; total 6 cycles. Repeat with O=1 → EPC strobe, iord=2, excpControl=1, then pcSource=5.
- beq with EQ=1 → pcWrite=1, pcSource=1 in EXEC; with EQ=0 → pcWrite stays 0.
- div with divZero=1 → excpControl=2 path. Div with divDone after 32 cycles → hiLoWrite pulses exactly once in cycle 33.
- lw then sw → lw takes iord=1 for 2 cycles, then mdrWrite, then regWrite/srcData=1; sw takes a single memWrite cycle.
- opcode 0x3F → excpControl=0 sequence. Reset pulsed during MD_WAIT → state_dbg=RESET asynchronously, with no hiLoWrite.

Source files
------------

// File: rtl/mips_control_unit.sv
// mips_control_unit: multicycle Moore controller sequencing fetch, decode, execute, mult/div handshakes and exceptions
module mips_control_unit #(
  parameter int MEM_WAIT = 2,
  parameter int SP_INIT  = 227
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       LT,
  input  logic       GT,
  input  logic       EQ,
  input  logic       O,
  input  logic       multDone,
  input  logic       divDone,
  input  logic       divZero,
  output logic [1:0] iord,
  output logic [1:0] excpControl,
  output logic [1:0] excpCtrl,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] ssControl,
  output logic [1:0] lsControl,
  output logic [2:0] srcWrite,
  output logic [2:0] pcSource,
  output logic [2:0] aluControl,
  output logic [2:0] shiftControl,
  output logic [3:0] srcData,
  output logic       shiftSrc,
  output logic       shiftAmt,
  output logic       srcRead,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       abWrite,
  output logic       mdrWrite,
  output logic       aluOutControl,
  output logic       epcControl,
  output logic       hiLoWrite,
  output logic       multControl,
  output logic       divControl,
  output logic [5:0] state_dbg
);
  typedef enum logic [5:0] {
    S_RESET = 6'd0, S_SPINIT, S_FETCH0, S_FWAIT, S_FLAST, S_DECODE,
    S_EX_ADD, S_EX_SUB, S_EX_AND, S_WB_RD,
    S_SH_LOAD, S_SH_SLL, S_SH_SRL, S_SH_SRA, S_SH_WB,
    S_JR, S_MFHI, S_MFLO, S_MULT, S_DIV, S_MULT_WAIT, S_DIV_WAIT, S_MD_DONE,
    S_EX_ADDI, S_EX_SLTI, S_WB_RT, S_LUI, S_BEQ, S_BNE, S_BR_TAKE,
    S_LW_ADDR, S_SW_ADDR, S_LW_RD, S_LW_MDR, S_LW_WB, S_SW,
    S_J, S_JAL0, S_JAL1, S_RTE,
    S_EXC_EPC, S_EXC_RD, S_EXC_MDR, S_EXC_PC
  } state_t;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;
  localparam logic [3:0] CNT_LAST = 4'(MEM_WAIT - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] exc_q, exc_d;
  logic       unused;
  assign unused = ^{zero, LT, GT, 8'(SP_INIT)};
  assign state_dbg = state_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    exc_d   = exc_q;
    case (state_q)
      S_RESET:  state_d = S_SPINIT;
      S_FETCH0, S_FWAIT: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == CNT_LAST) ? S_FLAST : S_FWAIT;
      end
      S_FLAST:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXC_EPC;
        exc_d   = 2'd0;
        case (opcode)
          6'h00: case (funct)
            6'h20:             state_d = S_EX_ADD;
            6'h22:             state_d = S_EX_SUB;
            6'h24:             state_d = S_EX_AND;
            6'h00, 6'h02, 6'h03: state_d = S_SH_LOAD;
            6'h08:             state_d = S_JR;
            6'h10:             state_d = S_MFHI;
            6'h12:             state_d = S_MFLO;
            6'h18:             state_d = S_MULT;
            6'h1a:             state_d = S_DIV;
            default: ;
          endcase
          6'h02: state_d = S_J;
          6'h03: state_d = S_JAL0;
          6'h04: state_d = S_BEQ;
          6'h05: state_d = S_BNE;
          6'h08: state_d = S_EX_ADDI;
          6'h0a: state_d = S_EX_SLTI;
          6'h0f: state_d = S_LUI;
          6'h10: state_d = S_RTE;
          6'h23: state_d = S_LW_ADDR;
          6'h2b: state_d = S_SW_ADDR;
          default: ;
        endcase
      end
      S_EX_ADD, S_EX_SUB, S_EX_ADDI: begin
        exc_d   = 2'd1;
        state_d = O ? S_EXC_EPC : (state_q == S_EX_ADDI ? S_WB_RT : S_WB_RD);
      end
      S_EX_AND:    state_d = S_WB_RD;
      S_EX_SLTI:   state_d = S_WB_RT;
      S_SH_LOAD:   state_d = funct == 6'h00 ? S_SH_SLL : funct == 6'h02 ? S_SH_SRL : S_SH_SRA;
      S_SH_SLL, S_SH_SRL, S_SH_SRA: state_d = S_SH_WB;
      S_MULT:      state_d = multDone ? S_MD_DONE : S_MULT_WAIT;
      S_MULT_WAIT: state_d = multDone ? S_MD_DONE : S_MULT_WAIT;
      S_DIV: begin
        exc_d   = 2'd2;
        state_d = divZero ? S_EXC_EPC : divDone ? S_MD_DONE : S_DIV_WAIT;
      end
      S_DIV_WAIT:  state_d = divDone ? S_MD_DONE : S_DIV_WAIT;
      S_BEQ:       state_d = EQ ? S_BR_TAKE : S_FETCH0;
      S_BNE:       state_d = EQ ? S_FETCH0 : S_BR_TAKE;
      S_LW_ADDR:   state_d = S_LW_RD;
      S_SW_ADDR:   state_d = S_SW;
      S_LW_RD, S_EXC_RD: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q != CNT_LAST ? state_q : state_q == S_LW_RD ? S_LW_MDR : S_EXC_MDR;
      end
      S_LW_MDR:    state_d = S_LW_WB;
      S_JAL0:      state_d = S_JAL1;
      S_EXC_EPC:   state_d = S_EXC_RD;
      S_EXC_MDR:   state_d = S_EXC_PC;
      default:     state_d = S_FETCH0;
    endcase
  end
  always_comb begin
    iord          = 2'd0;
    excpControl   = 2'd0;
    excpCtrl      = 2'd0;
    aluSrcA       = 2'd0;
    aluSrcB       = 2'd0;
    ssControl     = 2'd0;
    lsControl     = 2'd0;
    srcWrite      = 3'd0;
    pcSource      = 3'd0;
    aluControl    = ALU_PASS;
    shiftControl  = 3'd0;
    srcData       = 4'd0;
    shiftSrc      = 1'b0;
    shiftAmt      = 1'b0;
    srcRead       = 1'b0;
    pcWrite       = 1'b0;
    irWrite       = 1'b0;
    regWrite      = 1'b0;
    memWrite      = 1'b0;
    abWrite       = 1'b0;
    mdrWrite      = 1'b0;
    aluOutControl = 1'b0;
    epcControl    = 1'b0;
    hiLoWrite     = 1'b0;
    multControl   = 1'b0;
    divControl    = 1'b0;
    case (state_q)
      S_SPINIT: begin
        regWrite = 1'b1;
        srcWrite = 3'd2;
        srcData  = 4'd8;
      end
      S_FETCH0, S_FWAIT, S_FLAST: begin
        aluSrcB    = 2'd1;
        aluControl = ALU_ADD;
        irWrite    = state_q == S_FLAST;
        pcWrite    = state_q == S_FLAST;
      end
      S_DECODE: begin
        abWrite       = 1'b1;
        aluSrcB       = 2'd3;
        aluControl    = ALU_ADD;
        aluOutControl = 1'b1;
      end
      S_EX_ADD, S_EX_SUB, S_EX_AND: begin
        aluSrcA       = 2'd1;
        aluOutControl = 1'b1;
        aluControl    = state_q == S_EX_ADD ? ALU_ADD : state_q == S_EX_SUB ? ALU_SUB : ALU_AND;
      end
      S_WB_RD: begin
        regWrite = 1'b1;
        srcWrite = 3'd1;
      end
      S_SH_LOAD, S_SH_SLL, S_SH_SRL, S_SH_SRA: begin
        shiftSrc     = 1'b1;
        shiftAmt     = 1'b1;
        shiftControl = state_q == S_SH_LOAD ? 3'd1 : state_q == S_SH_SLL ? 3'd2 :
                       state_q == S_SH_SRL ? 3'd3 : 3'd4;
      end
      S_SH_WB: begin
        regWrite = 1'b1;
        srcWrite = 3'd1;
        srcData  = 4'd7;
      end
      S_JR: begin
        pcWrite = 1'b1;
        aluSrcA = 2'd1;
      end
      S_MFHI, S_MFLO: begin
        regWrite = 1'b1;
        srcWrite = 3'd1;
        srcData  = state_q == S_MFHI ? 4'd2 : 4'd3;
      end
      S_MULT:    multControl = 1'b1;
      S_DIV:     divControl = 1'b1;
      S_MD_DONE: hiLoWrite = 1'b1;
      S_EX_ADDI, S_EX_SLTI, S_LW_ADDR, S_SW_ADDR: begin
        aluSrcA       = 2'd1;
        aluSrcB       = 2'd2;
        aluOutControl = 1'b1;
        aluControl    = state_q == S_EX_SLTI ? ALU_CMP : ALU_ADD;
      end
      S_WB_RT:   regWrite = 1'b1;
      S_LUI: begin
        regWrite = 1'b1;
        srcData  = 4'd5;
      end
      S_BEQ, S_BNE: begin
        aluSrcA    = 2'd1;
        aluControl = ALU_CMP;
      end
      S_BR_TAKE: begin
        pcWrite  = 1'b1;
        pcSource = 3'd1;
      end
      S_LW_RD:   iord = 2'd1;
      S_LW_MDR:  mdrWrite = 1'b1;
      S_LW_WB: begin
        regWrite = 1'b1;
        srcData  = 4'd1;
      end
      S_SW: begin
        memWrite = 1'b1;
        iord     = 2'd1;
      end
      S_J: begin
        pcWrite  = 1'b1;
        pcSource = 3'd2;
      end
      S_JAL0:    aluOutControl = 1'b1;
      S_JAL1: begin
        regWrite = 1'b1;
        srcWrite = 3'd4;
        pcWrite  = 1'b1;
        pcSource = 3'd2;
      end
      S_RTE: begin
        pcWrite  = 1'b1;
        pcSource = 3'd4;
      end
      S_EXC_EPC: begin
        epcControl  = 1'b1;
        aluSrcB     = 2'd1;
        aluControl  = ALU_SUB;
        excpControl = exc_q;
      end
      S_EXC_RD: begin
        iord        = 2'd2;
        excpControl = exc_q;
      end
      S_EXC_MDR: begin
        mdrWrite    = 1'b1;
        excpControl = exc_q;
      end
      S_EXC_PC: begin
        pcWrite     = 1'b1;
        pcSource    = 3'd5;
        lsControl   = 2'd2;
        excpControl = exc_q;
      end
      default: ;
    endcase
  end
endmodule
